// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file (with storage cell Register)
// Brief    : 16x16 register file, one synchronous write port and two
//            combinational read ports with write-through bypass.
//            Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

module register_file #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] sel_in,
  input  logic [ADDR_W-1:0] sel_o1,
  input  logic [ADDR_W-1:0] sel_o2,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2
);

  localparam int c_DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] w_q [c_DEPTH];
  logic             w_byp_ok;

  genvar gi;
  generate
    for (gi = 0; gi < c_DEPTH; gi++) begin : g_regs
`ifdef REGFILE_ZERO_REG_EN
      if (gi == 0) begin : g_zero
        assign w_q[gi] = '0;
      end else begin : g_cell
        Register #(.WIDTH(WIDTH)) u_reg (
          .clk   (clk),
          .rst_n (rst_n),
          .i_en  (we && (sel_in == ADDR_W'(gi))),
          .i_d   (in),
          .o_q   (w_q[gi])
        );
      end
`else
      Register #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (we && (sel_in == ADDR_W'(gi))),
        .i_d   (in),
        .o_q   (w_q[gi])
      );
`endif
    end
  endgenerate

  // With the zero register, a write to address 0 must not bypass either.
`ifdef REGFILE_ZERO_REG_EN
  assign w_byp_ok = we && (sel_in != '0);
`else
  assign w_byp_ok = we;
`endif

  always_comb begin
    o1 = '0;
    o2 = '0;
    if (rst_n) begin
      o1 = (w_byp_ok && (sel_o1 == sel_in)) ? in : w_q[sel_o1];
      o2 = (w_byp_ok && (sel_o2 == sel_in)) ? in : w_q[sel_o2];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module   : tb_register_file
// Brief    : Directed self-checking bench for register_file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  sel_in;
  logic [3:0]  sel_o1;
  logic [3:0]  sel_o2;
  logic [15:0] in;
  logic [15:0] o1;
  logic [15:0] o2;

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .sel_in (sel_in),
    .sel_o1 (sel_o1),
    .sel_o2 (sel_o2),
    .in     (in),
    .o1     (o1),
    .o2     (o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1; sel_in = a; in = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; sel_in = '0; sel_o1 = '0; sel_o2 = '0; in = '0;

    // Reset held two cycles; outputs zero during reset even with a write pending
    we = 1'b1; sel_in = 4'd2; in = 16'h1111; sel_o1 = 4'd2; sel_o2 = 4'd2;
    #1;
    check("rst_o1_during", o1, 16'h0000);
    check("rst_o2_during", o2, 16'h0000);
    tick();
    tick();
    we = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel_o1 = 4'(i); sel_o2 = 4'(15 - i);
      #1;
      check($sformatf("rst_o1_a%0d", i), o1, 16'h0000);
      check($sformatf("rst_o2_a%0d", 15 - i), o2, 16'h0000);
    end

    // Write then hold with junk on in/sel_in and we=0
    write(4'd5, 16'h0010);
    in = 16'hFFFF; sel_in = 4'd5; sel_o1 = 4'd5; sel_o2 = 4'd5;
    #1;
    check("hold_o1_0", o1, 16'h0010);
    check("nobyp_we0_o2", o2, 16'h0010);
    tick();
    check("hold_o1_1", o1, 16'h0010);
    tick();
    check("hold_o1_2", o1, 16'h0010);

    // Bypass on port 2, then stored value
    sel_o2 = 4'd1; sel_o1 = 4'd5;
    #1;
    check("byp_pre_o2", o2, 16'h0000);
    we = 1'b1; sel_in = 4'd1; in = 16'h0001;
    #1;
    check("byp_o2", o2, 16'h0001);
    check("byp_o1_other", o1, 16'h0010);
    tick();
    we = 1'b0; in = 16'h0000;
    #1;
    check("byp_stored_o2", o2, 16'h0001);

    // Dual read and swapped selects
    write(4'd3, 16'hABCD);
    write(4'd12, 16'h1234);
    sel_o1 = 4'd3; sel_o2 = 4'd12;
    #1;
    check("dual_o1", o1, 16'hABCD);
    check("dual_o2", o2, 16'h1234);
    sel_o1 = 4'd12; sel_o2 = 4'd3;
    #1;
    check("swap_o1", o1, 16'h1234);
    check("swap_o2", o2, 16'hABCD);

    // Same entry on both ports with a matching write, then rewrite same value
    we = 1'b1; sel_in = 4'd9; in = 16'h0088; sel_o1 = 4'd9; sel_o2 = 4'd9;
    #1;
    check("same_byp_o1", o1, 16'h0088);
    check("same_byp_o2", o2, 16'h0088);
    tick();
    tick();
    we = 1'b0; in = 16'h0000;
    #1;
    check("same_rewrite_o1", o1, 16'h0088);
    check("same_rewrite_o2", o2, 16'h0088);

    // Reset during a pending write
    write(4'd7, 16'h5555);
    sel_o1 = 4'd7; sel_o2 = 4'd3;
    #1;
    check("mid_pre", o1, 16'h5555);
    rst_n = 1'b0; we = 1'b1; sel_in = 4'd7; in = 16'hAAAA; sel_o2 = 4'd7;
    #1;
    check("mid_rst_o1", o1, 16'h0000);
    check("mid_rst_o2", o2, 16'h0000);
    tick();
    rst_n = 1'b1; we = 1'b0; in = 16'h0000;
    #1;
    check("mid_after_e7", o1, 16'h0000);
    sel_o2 = 4'd3;
    #1;
    check("mid_after_e3", o2, 16'h0000);

    // Entry 0 behaviour depends on the zero-register build option
    sel_o1 = 4'd0; sel_o2 = 4'd15;
    we = 1'b1; sel_in = 4'd0; in = 16'h9999;
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("zero_byp", o1, 16'h0000);
`else
    check("zero_byp", o1, 16'h9999);
`endif
    check("zero_other", o2, 16'h0000);
    tick();
    we = 1'b0; in = 16'h0000;
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("zero_stored", o1, 16'h0000);
`else
    check("zero_stored", o1, 16'h9999);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
